// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer with branch/flush redirect.
// Define FETCH_DELAY_SLOT_EN for MIPS delay-slot branches (flush stays immediate).
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr;
    logic        discard, discard_nxt;
    logic        inst_vld, inst_vld_nxt;
    logic        capture;
    logic        redirect;
    logic [31:0] redir_tgt;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

`ifdef FETCH_DELAY_SLOT_EN
    logic        br_pend, br_pend_nxt;
    logic [31:0] br_tgt, br_tgt_nxt;

    assign redirect  = flush_i;
    assign redir_tgt = flush_target_i;
`else
    assign redirect  = flush_i | br_taken_i;
    assign redir_tgt = flush_i ? flush_target_i : br_target_i;
`endif

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        discard_nxt  = discard;
        inst_vld_nxt = inst_vld & stall_i;
        capture      = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (mem_ack_i) begin
                    if (discard || redirect) begin
                        discard_nxt = 1'b0;
                    end else if (inst_vld && stall_i) begin
                        // Decode slot still occupied: drop this beat and refetch after the stall.
                        state_nxt = HOLD;
                    end else begin
                        capture = 1'b1;
                    end
                end else if (redirect) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: if (!stall_i) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase

        if (capture) inst_vld_nxt = 1'b1;

`ifdef FETCH_DELAY_SLOT_EN
        br_pend_nxt = br_pend;
        br_tgt_nxt  = br_tgt;
        if (br_taken_i) begin
            br_pend_nxt = 1'b1;
            br_tgt_nxt  = word_align(br_target_i);
        end
        // The delivered instruction is the delay slot; the branch lands right after it.
        if (capture) begin
            pc_nxt      = br_pend_nxt ? br_tgt_nxt : pc + 32'd4;
            br_pend_nxt = 1'b0;
        end
        if (flush_i) br_pend_nxt = 1'b0;
`else
        if (capture) pc_nxt = pc + 32'd4;
`endif

        if (redirect) begin
            inst_vld_nxt = 1'b0;
            pc_nxt       = word_align(redir_tgt);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            discard   <= 1'b0;
            inst_vld  <= 1'b0;
            inst_o    <= 32'd0;
            inst_pc_o <= 32'd0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            discard  <= discard_nxt;
            inst_vld <= inst_vld_nxt;
            // Address is frozen while a request is in flight, even across a redirect.
            if (state != REQ || mem_ack_i) req_addr <= pc_nxt;
            if (capture) begin
                inst_o    <= mem_rdata_i;
                inst_pc_o <= req_addr;
            end
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            br_pend <= 1'b0;
            br_tgt  <= 32'd0;
        end else begin
            br_pend <= br_pend_nxt;
            br_tgt  <= br_tgt_nxt;
        end
    end
`endif

    assign mem_req_o    = (state == REQ);
    assign mem_addr_o   = req_addr;
    assign inst_valid_o = inst_vld;
    assign pc_o         = pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus randomized traffic checked by a
// stream scoreboard (expected program-order PCs) and a request-hold protocol monitor.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        flush_i;
    logic [31:0] flush_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] pc_o;

    always #5 clk_i = ~clk_i;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .stall_i        (stall_i),
        .br_taken_i     (br_taken_i),
        .br_target_i    (br_target_i),
        .flush_i        (flush_i),
        .flush_target_i (flush_target_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .pc_o           (pc_o)
    );

    typedef struct packed {
        logic        after;
        logic [31:0] slot;
        logic [31:0] tgt;
    } redir_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_deliv = 0;
    logic        chk_en = 1'b0;
    redir_t      redir_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_tgt();
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
        return 32'h8000_0000 | ($urandom & 32'h0000_3FFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                         input logic fl, input logic [31:0] ft, input logic ak);
        redir_t r;
        @(negedge clk_i);
        stall_i        = st;
        br_taken_i     = br;
        br_target_i    = bt;
        flush_i        = fl;
        flush_target_i = ft;
        mem_ack_i      = ak & mem_req_o;
        mem_rdata_i    = mem_ack_i ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;
        r.after = 1'b0;
        r.slot  = 32'd0;
        r.tgt   = fl ? ft : bt;
`ifdef FETCH_DELAY_SLOT_EN
        if (fl) redir_q.push_back(r);
`else
        if (fl || br) redir_q.push_back(r);
`endif
    endtask

    task automatic release_reset();
        redir_t r;
        r.after = 1'b0;
        r.slot  = 32'd0;
        r.tgt   = RESET_PC;
        rst_n_i = 1'b1;
        redir_q.push_back(r);
        chk_en  = 1'b1;
    endtask

    // Scoreboard/monitor: runs just after the driver so this cycle's inputs are visible.
    initial begin : monitor
        logic [31:0] stream_pc;
        logic        ds_pend;
        logic [31:0] ds_slot, ds_tgt, e;
        logic        prev_req, prev_ack;
        logic [31:0] prev_addr;
        redir_t      r;
        stream_pc = RESET_PC;
        ds_pend   = 1'b0;
        ds_slot   = 32'd0;
        ds_tgt    = 32'd0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = 32'd0;
        forever begin
            @(negedge clk_i);
            #1;
            if (chk_en && rst_n_i) begin
                if (prev_req && !prev_ack) begin
                    chk("req_held", {31'd0, mem_req_o}, 32'd1);
                    chk("addr_held", mem_addr_o, prev_addr);
                end
                if (inst_valid_o && !stall_i) begin
                    while (exp_q.size() < 4) begin
                        exp_q.push_back(stream_pc);
                        stream_pc += 32'd4;
                    end
                    e = exp_q.pop_front();
                    n_deliv++;
                    chk("deliver_pc", inst_pc_o, e);
                    chk("deliver_inst", inst_o, mem_word(e));
                    if (ds_pend && e == ds_slot) begin
                        exp_q.delete();
                        stream_pc = ds_tgt;
                        ds_pend   = 1'b0;
                    end
                end
            end
            while (redir_q.size() > 0) begin
                r = redir_q.pop_front();
                if (r.after) begin
                    ds_pend = 1'b1;
                    ds_slot = r.slot;
                    ds_tgt  = r.tgt & 32'hFFFF_FFFC;
                end else begin
                    exp_q.delete();
                    stream_pc = r.tgt & 32'hFFFF_FFFC;
                    ds_pend   = 1'b0;
                end
            end
            prev_req  = mem_req_o && chk_en && rst_n_i;
            prev_ack  = mem_ack_i;
            prev_addr = mem_addr_o;
        end
    end

    initial begin : main
        logic [31:0] a, v_inst, v_pc;
        int          pulses;
        logic        st, ak, fl, br;
        redir_t      r;
        rst_n_i = 1'b0; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'd0;
        flush_i = 1'b0; flush_target_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;

        repeat (3) @(negedge clk_i);
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, RESET_PC);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_inst_pc", inst_pc_o, 32'd0);
        release_reset();

        // Back-to-back acks: sequential addresses
        drive(0, 0, 0, 0, 0, 1);
        chk("seq_req", {31'd0, mem_req_o}, 32'd1);
        chk("seq_addr0", mem_addr_o, 32'h8000_0000);
        drive(0, 0, 0, 0, 0, 1);
        chk("seq_addr1", mem_addr_o, 32'h8000_0004);
        chk("seq_inst_pc0", inst_pc_o, 32'h8000_0000);
        drive(0, 0, 0, 0, 0, 1);
        chk("seq_addr2", mem_addr_o, 32'h8000_0008);
        chk("seq_inst_pc1", inst_pc_o, 32'h8000_0004);

        // Ack withheld for three cycles
        drive(0, 0, 0, 0, 0, 0);
        a = mem_addr_o;
        chk("slow_req0", {31'd0, mem_req_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, (i == 2));
            chk("slow_req", {31'd0, mem_req_o}, 32'd1);
            chk("slow_addr", mem_addr_o, a);
        end
        pulses = 0;
        repeat (4) begin
            drive(0, 0, 0, 0, 0, 0);
            if (inst_valid_o) pulses++;
        end
        chk("slow_pulses", pulses, 32'd1);

        // Branch at pc 0x80000010 with its request outstanding
        drive(0, 1, 32'h8000_0100, 0, 0, 0);
        chk("br_pc_before", pc_o, 32'h8000_0010);
`ifdef FETCH_DELAY_SLOT_EN
        r.after = 1'b1; r.slot = 32'h8000_0010; r.tgt = 32'h8000_0100;
        redir_q.push_back(r);
        drive(0, 0, 0, 0, 0, 1);
        chk("ds_pc_hold", pc_o, 32'h8000_0010);
        drive(0, 0, 0, 0, 0, 0);
        chk("ds_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("ds_slot_pc", inst_pc_o, 32'h8000_0010);
        chk("ds_next_addr", mem_addr_o, 32'h8000_0100);
`else
        drive(0, 0, 0, 0, 0, 1);
        chk("br_pc_after", pc_o, 32'h8000_0100);
        chk("br_addr_held", mem_addr_o, 32'h8000_0010);
        drive(0, 0, 0, 0, 0, 0);
        chk("br_dropped", {31'd0, inst_valid_o}, 32'd0);
        chk("br_next_req", {31'd0, mem_req_o}, 32'd1);
        chk("br_next_addr", mem_addr_o, 32'h8000_0100);
`endif
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("br_tgt_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("br_tgt_pc", inst_pc_o, 32'h8000_0100);

        // Five-cycle stall with acks arriving: HOLD then refetch
        drive(1, 0, 0, 0, 0, 1);
        v_inst = inst_o;
        v_pc   = inst_pc_o;
        chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
        repeat (4) begin
            drive(1, 0, 0, 0, 0, 1);
            chk("hold_no_req", {31'd0, mem_req_o}, 32'd0);
            chk("hold_inst", inst_o, v_inst);
            chk("hold_inst_pc", inst_pc_o, v_pc);
        end
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("resume_req", {31'd0, mem_req_o}, 32'd1);
        chk("resume_addr", mem_addr_o, v_pc + 32'd4);

        // Flush with a request outstanding, ack two cycles later
        drive(0, 0, 0, 1, 32'h8000_1003, 0);
        a = mem_addr_o;
        chk("fl_req", {31'd0, mem_req_o}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        chk("fl_addr_held", mem_addr_o, a);
        chk("fl_pc", pc_o, 32'h8000_1000);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("fl_dropped", {31'd0, inst_valid_o}, 32'd0);
        chk("fl_next_addr", mem_addr_o, 32'h8000_1000);

        // Wrap at top of address space, then asynchronous reset mid-request
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap_addr", mem_addr_o, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0);
        chk_en = 1'b0;
        chk("wrap_pc", pc_o, 32'h0000_0000);
        chk("wrap_inst_pc", inst_pc_o, 32'hFFFF_FFFC);
        chk("wrap_req", {31'd0, mem_req_o}, 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem_req_o}, 32'd0);
        chk("arst_pc", pc_o, RESET_PC);
        chk("arst_valid", {31'd0, inst_valid_o}, 32'd0);
        mem_ack_i = 1'b0;
        stall_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        release_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 99) < 30);
            ak = ($urandom_range(0, 99) < 55);
            fl = ($urandom_range(0, 99) < 3);
`ifdef FETCH_DELAY_SLOT_EN
            br = 1'b0;
`else
            br = ($urandom_range(0, 99) < 4);
`endif
            drive(st, br, rand_tgt(), fl, rand_tgt(), ak);
        end
        repeat (4) drive(0, 0, 0, 0, 0, 1);
        chk("deliveries_seen", {31'd0, (n_deliv > 200)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 stall_i  input  1  downstream cannot accept an instruction this cycle.
REQ-005 br_taken_i / br_target_i  input  1 / 32  branch redirect request and target.
REQ-006 flush_i / flush_target_i  input  1 / 32  exception flush request and vector.
REQ-007 mem_req_o / mem_addr_o  output  1 / 32  instruction-memory read request and word address.
REQ-008 mem_ack_i / mem_rdata_i  input  1 / 32  read completion and data; valid only when mem_ack_i=1.
REQ-009 inst_valid_o / inst_o / inst_pc_o  output  1 / 32 / 32  fetched instruction to decode and its PC.
REQ-010 pc_o  output  32  current fetch PC (address of the outstanding or next request).

Function
REQ-011 The FSM SHALL have states IDLE, REQ, HOLD; IDLE->REQ unconditionally one cycle after reset release.
REQ-012 In REQ, mem_req_o SHALL be 1 and mem_addr_o=pc_o, both held stable until the cycle mem_ack_i=1; same-cycle ack is legal.
REQ-013 A started request SHALL never be withdrawn before ack, even on redirect.
REQ-014 On ack with no discard pending: inst_o<=mem_rdata_i, inst_pc_o<=pc_o, inst_valid_o<=1, pc_o<=pc_o+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-015 Instruction is consumed on a cycle with inst_valid_o=1 and stall_i=0; then inst_valid_o SHALL drop unless a new ack lands that same cycle.
REQ-016 If an ack arrives while inst_valid_o=1 and stall_i=1, the FSM SHALL enter HOLD, mem_req_o=0, keeping inst_o/inst_pc_o unchanged; the new data is not captured and the PC is not advanced (refetch on exit).
REQ-017 HOLD->REQ on the first cycle stall_i=0; no request issued while in HOLD.
REQ-018 Redirect priority: flush_i > br_taken_i > sequential; latest redirect before the next issued request wins.
REQ-019 Redirect SHALL load pc_o with target & 32'hFFFF_FFFC next edge; if a request is outstanding, a discard flag is set, its ack data is dropped (inst_valid_o not asserted), then a request to the new PC is issued the cycle after ack.
REQ-020 Redirect in the same cycle as ack SHALL drop that ack's data.
REQ-021 Redirect SHALL clear inst_valid_o at the next edge, including in HOLD.

Reset
REQ-022 While rst_n_i=0: pc_o=RESET_PC, mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, discard/pending flags 0, state IDLE.
REQ-023 Reset asserted mid-request SHALL drop mem_req_o immediately (asynchronously); the memory side tolerates abandonment on reset only.

Configuration
REQ-024 Macro FETCH_DELAY_SLOT_EN SHALL select MIPS branch delay-slot behaviour.
REQ-025 Defined: br_taken_i SHALL be latched as pending; the instruction at the current pc_o (delay slot) is fetched and delivered normally, then pc_o<=target; flush_i remains immediate and clears any pending branch.
REQ-026 Undefined: br_taken_i SHALL redirect immediately per REQ-019; no pending-branch register exists.

Verification
REQ-027 Reset release, mem_ack_i=1 every request, stall_i=0 -> mem_addr_o 0x80000000, 0x80000004, 0x80000008 on consecutive requests; inst_pc_o follows one cycle later.
REQ-028 Ack delayed 3 cycles -> mem_req_o and mem_addr_o stable for 4 cycles; exactly one inst_valid_o pulse.
REQ-029 stall_i=1 for 5 cycles while inst_valid_o=1 -> inst_o unchanged, mem_req_o=0 in HOLD; after release next fetch resumes at the correct PC with no instruction lost or duplicated.
REQ-030 flush_i=1, flush_target_i=0x80001003 with request outstanding and ack 2 cycles later -> returned data dropped, next mem_addr_o=0x80001000.
REQ-031 br_taken_i with br_target_i=0x80000100 at pc_o=0x80000010: macro defined -> 0x80000010 delivered, next request 0x80000100; undefined -> next request 0x80000100, 0x80000010 not delivered.
REQ-032 pc_o=0xFFFFFFFC, ack -> pc_o=0x00000000; rst_n_i pulsed low mid-request -> mem_req_o=0 immediately, pc_o=RESET_PC.
